mux8_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 8:1 multiplexer output among 8 requesters.
//   - Drives the mux select and a registered copy of the selected data bit.
//   - Sits between the request sources and the mux8 datapath; owns sel.
//   - Prevents starvation with a per-grant hold limit.

---
 rtl/mux8_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select of an 8:1 mux and registers the selected bit.
// A per-grant hold limit forces rotation when other requesters are waiting.
module mux8_rr_arbiter #(
    parameter int N        = 8,
    parameter int SELW     = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    D,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            y
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, nstate;
    logic [SELW-1:0] ptr, nptr;
    logic [HW-1:0]   hold_cnt, nhold;
    logic [N-1:0]    ngnt;
    logic [SELW-1:0] nsel;
    logic            nbusy;

    logic [SELW:0]   hit_req, hit_oth;
    logic [N-1:0]    others;
    logic            limit_hit;
    logic            take;
    logic [SELW-1:0] win;

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] x);
        if (int'(x) == N - 1)
            return '0;
        return x + SELW'(1);
    endfunction

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod N.
    function automatic logic [SELW:0] rr_search(input logic [N-1:0] r,
                                               input logic [SELW-1:0] start);
        logic [SELW:0] res;
        int            idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (r[idx])
                res = {1'b1, idx[SELW-1:0]};
        end
        return res;
    endfunction

    assign others    = req & ~(N'(1) << sel);
    assign hit_req   = rr_search(req, ptr);
    assign hit_oth   = rr_search(others, wrap_inc(sel));
    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM);

    always_comb begin
        nstate = state;
        nptr   = ptr;
        nhold  = hold_cnt;
        ngnt   = gnt;
        nsel   = sel;
        nbusy  = busy;
        take   = 1'b0;
        win    = '0;

        case (state)
            IDLE: begin
                if (hit_req[SELW]) begin
                    take = 1'b1;
                    win  = hit_req[SELW-1:0];
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    if (!limit_hit) begin
                        nhold = hold_cnt + HW'(1);
                    end else if (hit_oth[SELW]) begin
                        take = 1'b1;
                        win  = hit_oth[SELW-1:0];
                    end else begin
                        // Nobody else is waiting: keep the grant but restart the hold window.
                        nhold = '0;
                    end
                end else if (hit_req[SELW]) begin
                    take = 1'b1;
                    win  = hit_req[SELW-1:0];
                end else begin
                    nstate = IDLE;
                    ngnt   = '0;
                    nbusy  = 1'b0;
                    nhold  = '0;
                end
            end
            default: nstate = IDLE;
        endcase

        if (take) begin
            nstate = GRANT;
            nsel   = win;
            ngnt   = N'(1) << win;
            nbusy  = 1'b1;
            nptr   = wrap_inc(win);
            nhold  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            y        <= 1'b0;
        end else begin
            state    <= nstate;
            ptr      <= nptr;
            hold_cnt <= nhold;
            gnt      <= ngnt;
            sel      <= nsel;
            busy     <= nbusy;
            y        <= nbusy ? D[nsel] : 1'b0;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed, table-driven bench for mux8_rr_arbiter (MAX_HOLD = 4, D mostly 8'b10110101).
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] D;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] d;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       y;
    } vec_t;

    vec_t vq[$];

    mux8_rr_arbiter #(.N(8), .SELW(3), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .D   (D),
        .gnt (gnt),
        .sel (sel),
        .busy(busy),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] r, input logic [7:0] d, input logic [7:0] g,
                       input logic [2:0] s, input logic b, input logic yy);
        vq.push_back('{r, d, g, s, b, yy});
    endtask

    task automatic check_outs(input string tag, input logic [7:0] g, input logic [2:0] s,
                              input logic b, input logic yy);
        check({tag, " gnt"},  32'(gnt),  32'(g));
        check({tag, " sel"},  32'(sel),  32'(s));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " y"},    32'(y),    32'(yy));
    endtask

    initial begin
        // Rows: inputs applied before an edge, expected outputs just after it.
        // Reset release with every requester asserted
        add(8'hFF, 8'hB5, 8'h01, 3'd0, 1'b1, 1'b1);
        // Single requester 5 for three cycles, then drop
        add(8'h20, 8'hB5, 8'h20, 3'd5, 1'b1, 1'b1);
        add(8'h20, 8'hB5, 8'h20, 3'd5, 1'b1, 1'b1);
        add(8'h20, 8'hB5, 8'h20, 3'd5, 1'b1, 1'b1);
        add(8'h00, 8'hB5, 8'h00, 3'd5, 1'b0, 1'b0);
        add(8'h00, 8'hB5, 8'h00, 3'd5, 1'b0, 1'b0);
        // Grant 7 so ptr wraps to 0, then idle
        add(8'h80, 8'hB5, 8'h80, 3'd7, 1'b1, 1'b1);
        add(8'h00, 8'hB5, 8'h00, 3'd7, 1'b0, 1'b0);
        // Fairness with req=8'h81 held: 01 x4, 80 x4, 01
        for (int i = 0; i < 4; i++) add(8'h81, 8'hB5, 8'h01, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) add(8'h81, 8'hB5, 8'h80, 3'd7, 1'b1, 1'b1);
        add(8'h81, 8'hB5, 8'h01, 3'd0, 1'b1, 1'b1);
        // Back-to-back handoff 2 -> 6 with no idle bubble
        add(8'h04, 8'hB5, 8'h04, 3'd2, 1'b1, 1'b1);
        add(8'h44, 8'hB5, 8'h04, 3'd2, 1'b1, 1'b1);
        add(8'h40, 8'hB5, 8'h40, 3'd6, 1'b1, 1'b0);
        // Wrap-around: grant 7, then req=8'h09 picks 0, then 3
        add(8'h80, 8'hB5, 8'h80, 3'd7, 1'b1, 1'b1);
        add(8'h09, 8'hB5, 8'h01, 3'd0, 1'b1, 1'b1);
        add(8'h08, 8'hB5, 8'h08, 3'd3, 1'b1, 1'b0);
        // Hold limit with nobody waiting keeps the grant; D change shows up in y
        for (int i = 0; i < 4; i++) add(8'h08, 8'hB5, 8'h08, 3'd3, 1'b1, 1'b0);
        add(8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
        // Sweep grants 0..7: y = 1,0,1,0,1,1,0,1
        add(8'h01, 8'hB5, 8'h01, 3'd0, 1'b1, 1'b1);
        add(8'h02, 8'hB5, 8'h02, 3'd1, 1'b1, 1'b0);
        add(8'h04, 8'hB5, 8'h04, 3'd2, 1'b1, 1'b1);
        add(8'h08, 8'hB5, 8'h08, 3'd3, 1'b1, 1'b0);
        add(8'h10, 8'hB5, 8'h10, 3'd4, 1'b1, 1'b1);
        add(8'h20, 8'hB5, 8'h20, 3'd5, 1'b1, 1'b1);
        add(8'h40, 8'hB5, 8'h40, 3'd6, 1'b1, 1'b0);
        add(8'h80, 8'hB5, 8'h80, 3'd7, 1'b1, 1'b1);

        rst = 1'b1;
        req = 8'hFF;
        D   = 8'hB5;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vq[i]) begin
            req = vq[i].req;
            D   = vq[i].d;
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), vq[i].gnt, vq[i].sel, vq[i].busy, vq[i].y);
            check($sformatf("v%0d onehot", i), 32'($onehot0(gnt)), 32'd1);
        end

        // Async reset between edges while grant 7 is active
        req = 8'h80;
        @(posedge clk);
        #1;
        check("pre-rst busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async-rst", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'hFF;
        @(posedge clk);
        #1;
        check_outs("rst-held", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post-rst", 8'h01, 3'd0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
